// File: rtl/y86_fetch_queue.sv
// Y86-64 fetch stage: byte-granular circular prefetch queue, head-byte length decode,
// valid/ready instruction output. Optional retired-instruction counter under FETCH_STATS_EN.
module y86_fetch_queue #(
    parameter int ADDR_W      = 64,
    parameter int FETCH_BYTES = 2,
    parameter int BUF_DEPTH   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_rvalid,
    input  logic [8*FETCH_BYTES-1:0] mem_rdata,
    input  logic                     mem_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               icode,
    output logic [3:0]               ifun,
    output logic [3:0]               rA,
    output logic [3:0]               rB,
    output logic [63:0]              valC,
    output logic [ADDR_W-1:0]        valP,
    output logic                     instr_valid,
    output logic                     imem_error,
    output logic                     halted,
    output logic [31:0]              instr_count
);
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int CW = IW + 1;

    function automatic logic [3:0] f_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       f_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
            4'h3, 4'h4, 4'h5:       f_len = 4'd10;
            4'h7, 4'h8:             f_len = 4'd9;
            default:                f_len = 4'd1;
        endcase
    endfunction

    function automatic logic f_legal(input logic [3:0] ic, input logic [3:0] fn);
        case (ic)
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: f_legal = (fn == 4'h0);
            4'h2, 4'h7:                                           f_legal = (fn <= 4'h6);
            4'h6:                                                 f_legal = (fn <= 4'h3);
            default:                                              f_legal = 1'b0;
        endcase
    endfunction

    logic [7:0]        r_buf [BUF_DEPTH];
    logic [IW-1:0]     r_head;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_head_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_outstanding;
    logic              r_drop;
    logic              r_err_pend;
    logic              r_halted;

    logic [7:0]        w_b [10];
    logic [3:0]        w_icode;
    logic [3:0]        w_ifun;
    logic [3:0]        w_len;
    logic              w_legal;
    logic              w_avail_ok;
    logic              w_err_out;
    logic              w_out_valid;
    logic              w_fire;
    logic              w_pop;
    logic              w_halt_set;
    logic [CW-1:0]     w_free;
    logic              w_req;
    logic              w_rsp_live;
    logic              w_push;

    // Window of the ten bytes starting at the queue head (longest instruction).
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            w_b[k] = r_buf[r_head + IW'(k)];
        end
    end

    assign w_icode     = w_b[0][7:4];
    assign w_ifun      = w_b[0][3:0];
    assign w_len       = f_len(w_icode);
    assign w_legal     = f_legal(w_icode, w_ifun);
    assign w_avail_ok  = (r_count >= CW'(w_len));
    // A pending fault is reported only once the head cannot be completed from buffered bytes.
    assign w_err_out   = r_err_pend && !w_avail_ok;
    assign w_out_valid = !r_halted && !redirect_valid && (w_avail_ok || r_err_pend);
    assign w_fire      = w_out_valid && out_ready;
    assign w_pop       = w_fire && !w_err_out;
    assign w_halt_set  = w_fire && (w_err_out || (w_icode == 4'h0) || !w_legal);
    assign w_free      = CW'(BUF_DEPTH) - r_count;
    assign w_req       = rst_n && !redirect_valid && !r_outstanding && !r_drop && !r_halted
                         && !r_err_pend && (w_free >= CW'(FETCH_BYTES));
    assign w_rsp_live  = rst_n && mem_rvalid && r_outstanding && !r_drop && !redirect_valid;
    assign w_push      = w_rsp_live && !mem_err;

    assign mem_req   = w_req;
    assign mem_addr  = r_fetch_pc;
    assign out_valid = w_out_valid;
    assign halted    = r_halted;

    // Response bytes land at the tail; pops never overlap the tail region written here.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                r_buf[r_head + IW'(r_count) + IW'(k)] <= mem_rdata[8*k +: 8];
            end
        end
    end

    // Queue pointers, PCs and fetch/stop control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head        <= {IW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_head_pc     <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= (r_outstanding || r_drop) && !mem_rvalid;
            r_err_pend    <= 1'b0;
            r_halted      <= 1'b0;
        end else if (redirect_valid) begin
            r_count       <= {CW{1'b0}};
            r_head_pc     <= redirect_pc;
            r_fetch_pc    <= redirect_pc;
            r_outstanding <= 1'b0;
            r_drop        <= (r_outstanding || r_drop) && !mem_rvalid;
            r_err_pend    <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            if (w_req) begin
                r_outstanding <= 1'b1;
                r_fetch_pc    <= r_fetch_pc + ADDR_W'(FETCH_BYTES);
            end
            if (mem_rvalid) begin
                if (r_drop) begin
                    r_drop <= 1'b0;
                end else if (r_outstanding) begin
                    r_outstanding <= 1'b0;
                    if (mem_err) begin
                        r_err_pend <= 1'b1;
                    end
                end
            end
            r_count <= r_count + (w_push ? CW'(FETCH_BYTES) : {CW{1'b0}})
                               - (w_pop ? CW'(w_len) : {CW{1'b0}});
            if (w_pop) begin
                r_head    <= r_head + IW'(w_len);
                r_head_pc <= r_head_pc + ADDR_W'(w_len);
            end
            if (w_halt_set) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Decoded view of the head instruction, or the fault record.
    always_comb begin
        icode       = w_icode;
        ifun        = w_ifun;
        rA          = 4'hF;
        rB          = 4'hF;
        valC        = 64'h0;
        valP        = r_head_pc + ADDR_W'(w_len);
        instr_valid = w_legal;
        imem_error  = 1'b0;
        if (w_err_out) begin
            icode       = 4'h0;
            ifun        = 4'h0;
            valP        = r_head_pc;
            instr_valid = 1'b0;
            imem_error  = 1'b1;
        end else begin
            if ((w_len == 4'd2) || (w_len == 4'd10)) begin
                rA = w_b[1][7:4];
                rB = w_b[1][3:0];
            end else begin
                rA = 4'hF;
                rB = 4'hF;
            end
            case (w_icode)
                4'h3, 4'h4, 4'h5: valC = {w_b[9], w_b[8], w_b[7], w_b[6],
                                          w_b[5], w_b[4], w_b[3], w_b[2]};
                4'h7, 4'h8:       valC = {w_b[8], w_b[7], w_b[6], w_b[5],
                                          w_b[4], w_b[3], w_b[2], w_b[1]};
                default:          valC = 64'h0;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_instr_count;

    // Counts accepted, legal, non-faulted instructions; survives redirects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr_count <= 32'h0;
        end else if (w_fire && !w_err_out && w_legal) begin
            r_instr_count <= r_instr_count + 32'h1;
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = 32'h0;
`endif

endmodule
